// File: rtl/jtframe_sdram_pkg.sv
// Shared SDRAM-side definitions for the bank-sharing logic.
//   ba_state_t : grant state encoding (IDLE / GAME / AUX)
//   strobe_t   : bundle of the three bank strobes (ack, dst, rdy)
//   STB_NONE   : all-zero strobe bundle used for the unselected requester
//   sat_inc4   : 4-bit saturating increment for the starvation counter
package jtframe_sdram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAME = 2'd1,
    AUX  = 2'd2
  } ba_state_t;

  typedef struct packed {
    logic ack;
    logic dst;
    logic rdy;
  } strobe_t;

  localparam strobe_t STB_NONE = '0;

  localparam logic [3:0] STARVE_SAT = 4'd15;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v, input logic en);
    if (en && v != STARVE_SAT) return v + 4'd1;
    return v;
  endfunction

endpackage

// File: rtl/jtframe_ba_share.sv
// Shares one SDRAM bank port between the game (primary) and an auxiliary
// master. A grant is held from the cycle after the request until the bank's
// rdy, or until the timeout counter expires.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   game_addr/rd/wr/din/din_m       : game request bus
//   game_ack/dst/rdy                : bank strobes routed to the game
//   aux_addr/rd/wr/din/din_m        : aux request bus; aux_lock fences it off
//   aux_ack/dst/rdy, aux_dout       : strobes and latched read data for aux
//   ba_addr/rd/wr/din/din_m         : request towards the SDRAM bank
//   ba_ack/dst/rdy, data_read       : bank strobes and read data
//   owner, busy, tout               : grant owner, grant active, sticky timeout
module jtframe_ba_share
  import jtframe_sdram_pkg::*;
#(
  parameter int unsigned AW     = 22,
  parameter int unsigned STARVE = 8,
  parameter int unsigned TOUTW  = 8
) (
  input  logic          clk,
  input  logic          rst,

  input  logic [AW-1:0] game_addr,
  input  logic          game_rd,
  input  logic          game_wr,
  input  logic [15:0]   game_din,
  input  logic [1:0]    game_din_m,
  output logic          game_ack,
  output logic          game_dst,
  output logic          game_rdy,

  input  logic [AW-1:0] aux_addr,
  input  logic          aux_rd,
  input  logic          aux_wr,
  input  logic [15:0]   aux_din,
  input  logic [1:0]    aux_din_m,
  input  logic          aux_lock,
  output logic          aux_ack,
  output logic          aux_dst,
  output logic          aux_rdy,
  output logic [15:0]   aux_dout,

  output logic [AW-1:0] ba_addr,
  output logic          ba_rd,
  output logic          ba_wr,
  output logic [15:0]   ba_din,
  output logic [1:0]    ba_din_m,
  input  logic          ba_ack,
  input  logic          ba_dst,
  input  logic          ba_rdy,
  input  logic [15:0]   data_read,

  output logic          owner,
  output logic          busy,
  output logic          tout
);

  localparam logic [3:0]       STARVE_L = 4'(STARVE);
  localparam logic [TOUTW-1:0] TMAX     = '1;

  ba_state_t        state, nxt_state;
  logic             nxt_owner;
  logic [3:0]       starve_cnt, nxt_starve;
  logic [TOUTW-1:0] timer;
  logic             acked;
  logic             tout_set;
  logic             game_req, aux_req;

  strobe_t bank_stb, game_stb, aux_stb;

  assign game_req = game_rd | game_wr;
  assign aux_req  = (aux_rd | aux_wr) & ~aux_lock;

  // State register and the registered side state that tracks it
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      starve_cnt <= '0;
      acked      <= 1'b0;
      timer      <= '0;
      tout       <= 1'b0;
      aux_dout   <= '0;
    end else begin
      state      <= nxt_state;
      owner      <= nxt_owner;
      starve_cnt <= nxt_starve;
      if (tout_set) tout <= 1'b1;
      // Held at zero while idle, so every grant starts counting from 0
      if (state == IDLE) timer <= '0;
      else               timer <= timer + TOUTW'(1);
      if (nxt_state == IDLE)               acked <= 1'b0;
      else if (state != IDLE && ba_ack)    acked <= 1'b1;
      if (state == AUX && ba_dst) aux_dout <= data_read;
    end
  end

  // Next-state logic: arbitration in IDLE, completion/timeout while granted
  always_comb begin
    nxt_state  = state;
    nxt_owner  = owner;
    nxt_starve = starve_cnt;
    tout_set   = 1'b0;
    unique case (state)
      IDLE: begin
        if (aux_req && (starve_cnt >= STARVE_L || !game_req)) begin
          nxt_state  = AUX;
          nxt_owner  = 1'b1;
          nxt_starve = '0;
        end else if (game_req) begin
          nxt_state  = GAME;
          nxt_owner  = 1'b0;
          nxt_starve = sat_inc4(starve_cnt, aux_req);
        end else if (!aux_req) begin
          nxt_starve = '0;
        end
      end
      GAME, AUX: begin
        if (ba_rdy) begin
          nxt_state = IDLE;
        end else if (timer == TMAX) begin
          nxt_state = IDLE;
          tout_set  = 1'b1;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // Output logic: bank drive and strobe routing follow the current state
  always_comb begin
    bank_stb = '{ack: ba_ack, dst: ba_dst, rdy: ba_rdy};
    game_stb = STB_NONE;
    aux_stb  = STB_NONE;
    ba_addr  = game_addr;
    ba_din   = game_din;
    ba_din_m = game_din_m;
    ba_rd    = 1'b0;
    ba_wr    = 1'b0;
    unique case (state)
      GAME: begin
        game_stb = bank_stb;
        ba_rd    = game_rd & ~acked;
        ba_wr    = game_wr & ~acked;
      end
      AUX: begin
        aux_stb  = bank_stb;
        ba_addr  = aux_addr;
        ba_din   = aux_din;
        ba_din_m = aux_din_m;
        ba_rd    = aux_rd & ~acked;
        ba_wr    = aux_wr & ~acked;
      end
      default: ;
    endcase
    game_ack = game_stb.ack;
    game_dst = game_stb.dst;
    game_rdy = game_stb.rdy;
    aux_ack  = aux_stb.ack;
    aux_dst  = aux_stb.dst;
    aux_rdy  = aux_stb.rdy;
    busy     = (state != IDLE);
  end

endmodule

// File: tb/tb_jtframe_ba_share.sv
module tb_jtframe_ba_share;
  localparam int unsigned AW = 22;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] game_addr, aux_addr, ba_addr;
  logic          game_rd, game_wr, aux_rd, aux_wr, aux_lock;
  logic [15:0]   game_din, aux_din, ba_din, aux_dout, data_read;
  logic [1:0]    game_din_m, aux_din_m, ba_din_m;
  logic          game_ack, game_dst, game_rdy, aux_ack, aux_dst, aux_rdy;
  logic          ba_rd, ba_wr, ba_ack, ba_dst, ba_rdy;
  logic          owner, busy, tout;

  int checks   = 0;
  int failures = 0;

  jtframe_ba_share #(.AW(AW), .STARVE(8), .TOUTW(4)) dut (
    .clk(clk), .rst(rst),
    .game_addr(game_addr), .game_rd(game_rd), .game_wr(game_wr),
    .game_din(game_din), .game_din_m(game_din_m),
    .game_ack(game_ack), .game_dst(game_dst), .game_rdy(game_rdy),
    .aux_addr(aux_addr), .aux_rd(aux_rd), .aux_wr(aux_wr),
    .aux_din(aux_din), .aux_din_m(aux_din_m), .aux_lock(aux_lock),
    .aux_ack(aux_ack), .aux_dst(aux_dst), .aux_rdy(aux_rdy), .aux_dout(aux_dout),
    .ba_addr(ba_addr), .ba_rd(ba_rd), .ba_wr(ba_wr), .ba_din(ba_din),
    .ba_din_m(ba_din_m), .ba_ack(ba_ack), .ba_dst(ba_dst), .ba_rdy(ba_rdy),
    .data_read(data_read), .owner(owner), .busy(busy), .tout(tout)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    game_addr = '0; game_rd = 0; game_wr = 0; game_din = '0; game_din_m = '0;
    aux_addr = '0; aux_rd = 0; aux_wr = 0; aux_din = '0; aux_din_m = '0; aux_lock = 0;
    ba_ack = 0; ba_dst = 0; ba_rdy = 0; data_read = '0;
    tick; tick;
    rst = 1'b0;
    tick;
    checks++;
    if ({busy, owner, tout, ba_rd, ba_wr} !== 5'b0) begin
      failures++; $display("FAIL reset_status got=%b exp=00000", {busy, owner, tout, ba_rd, ba_wr});
    end
    checks++;
    if (aux_dout !== 16'h0) begin
      failures++; $display("FAIL reset_aux_dout got=%h exp=0000", aux_dout);
    end
    checks++;
    if (dut.starve_cnt !== 4'd0) begin
      failures++; $display("FAIL reset_starve got=%0d exp=0", dut.starve_cnt);
    end
  endtask

  task automatic test_game_read;
    game_addr = 22'h1234; game_din = 16'h5A5A; game_rd = 1;
    #1;
    checks++;
    if ({busy, ba_rd} !== 2'b00) begin
      failures++; $display("FAIL game_latency got=%b exp=00", {busy, ba_rd});
    end
    tick;
    checks++;
    if ({ba_rd, ba_wr, busy, owner} !== 4'b1010 || ba_addr !== 22'h1234) begin
      failures++; $display("FAIL game_grant got=%b/%h exp=1010/001234", {ba_rd, ba_wr, busy, owner}, ba_addr);
    end
    ba_ack = 1; #1;
    checks++;
    if ({game_ack, aux_ack} !== 2'b10) begin
      failures++; $display("FAIL game_ack_route got=%b exp=10", {game_ack, aux_ack});
    end
    tick;
    ba_ack = 0; game_rd = 0; #1;
    checks++;
    if ({ba_rd, busy} !== 2'b01) begin
      failures++; $display("FAIL game_rd_drop got=%b exp=01", {ba_rd, busy});
    end
    ba_dst = 1; ba_rdy = 1; data_read = 16'h1111; #1;
    checks++;
    if ({game_dst, game_rdy, aux_dst, aux_rdy} !== 4'b1100) begin
      failures++; $display("FAIL game_rdy_route got=%b exp=1100", {game_dst, game_rdy, aux_dst, aux_rdy});
    end
    tick;
    ba_dst = 0; ba_rdy = 0; #1;
    checks++;
    if ({busy, aux_dout} !== {1'b0, 16'h0000}) begin
      failures++; $display("FAIL game_done got=%b/%h exp=0/0000", busy, aux_dout);
    end
  endtask

  task automatic test_aux_read;
    aux_addr = 22'h3FFFFF; aux_rd = 1;
    tick;
    checks++;
    if ({ba_rd, busy, owner} !== 3'b111 || ba_addr !== 22'h3FFFFF) begin
      failures++; $display("FAIL aux_grant got=%b/%h exp=111/3fffff", {ba_rd, busy, owner}, ba_addr);
    end
    ba_ack = 1; #1;
    checks++;
    if ({aux_ack, game_ack} !== 2'b10) begin
      failures++; $display("FAIL aux_ack_route got=%b exp=10", {aux_ack, game_ack});
    end
    tick;
    ba_ack = 0; aux_rd = 0;
    ba_dst = 1; ba_rdy = 1; data_read = 16'hBEEF; #1;
    checks++;
    if ({aux_dst, aux_rdy, game_ack, game_dst, game_rdy} !== 5'b11000) begin
      failures++; $display("FAIL aux_rdy_route got=%b exp=11000", {aux_dst, aux_rdy, game_ack, game_dst, game_rdy});
    end
    tick;
    ba_dst = 0; ba_rdy = 0; #1;
    checks++;
    if ({busy, aux_dout} !== {1'b0, 16'hBEEF}) begin
      failures++; $display("FAIL aux_dout_load got=%b/%h exp=0/beef", busy, aux_dout);
    end
    data_read = 16'h0000; ba_dst = 1;
    tick;
    ba_dst = 0;
    checks++;
    if (aux_dout !== 16'hBEEF) begin
      failures++; $display("FAIL aux_dout_hold got=%h exp=beef", aux_dout);
    end
  endtask

  task automatic test_both_and_same_cycle;
    game_rd = 1; game_wr = 1; game_din_m = 2'b10; game_din = 16'h0F0F;
    tick;
    checks++;
    if ({ba_rd, ba_wr, ba_din_m, ba_din} !== {2'b11, 2'b10, 16'h0F0F}) begin
      failures++; $display("FAIL both_rw got=%b/%b/%h exp=11/10/0f0f", {ba_rd, ba_wr}, ba_din_m, ba_din);
    end
    ba_ack = 1; ba_rdy = 1; game_rd = 0; game_wr = 0; #1;
    checks++;
    if ({game_ack, game_rdy} !== 2'b11) begin
      failures++; $display("FAIL ack_rdy_same got=%b exp=11", {game_ack, game_rdy});
    end
    tick;
    ba_ack = 0; ba_rdy = 0; #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL ack_rdy_idle got=%b exp=0", busy);
    end
  endtask

  task automatic test_starvation;
    int  game_grants = 0;
    bit  got_aux = 0;
    game_addr = 22'h0100; aux_addr = 22'h0200;
    game_rd = 1; aux_rd = 1;
    for (int g = 0; g < 12 && !got_aux; g++) begin
      for (int w = 0; w < 3 && !busy; w++) tick;
      checks++;
      if (busy !== 1'b1) begin
        failures++; $display("FAIL starve_grant_wait got=%b exp=1 grant=%0d", busy, g);
      end
      if (owner) begin
        got_aux = 1;
        checks++;
        if (dut.starve_cnt !== 4'd0) begin
          failures++; $display("FAIL starve_clear got=%0d exp=0", dut.starve_cnt);
        end
        aux_rd = 0; game_rd = 0;
      end else begin
        game_grants++;
        if (g == 7) begin
          checks++;
          if (dut.starve_cnt !== 4'd8) begin
            failures++; $display("FAIL starve_count got=%0d exp=8", dut.starve_cnt);
          end
        end
      end
      ba_ack = 1; ba_rdy = 1;
      tick;
      ba_ack = 0; ba_rdy = 0; #1;
      if (g == 0) begin
        checks++;
        if (busy !== 1'b0) begin
          failures++; $display("FAIL bubble got=%b exp=0", busy);
        end
      end
    end
    checks++;
    if (game_grants !== 8 || got_aux !== 1'b1) begin
      failures++; $display("FAIL starve_grants got=%0d/%0d exp=8/1", game_grants, got_aux);
    end
  endtask

  task automatic test_lock;
    int seen = 0;
    aux_lock = 1; aux_wr = 1; aux_addr = 22'h000ABC; aux_din = 16'hC0DE; aux_din_m = 2'b01;
    for (int i = 0; i < 100; i++) begin
      tick;
      if (busy || ba_wr) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++; $display("FAIL lock_block got=%0d exp=0", seen);
    end
    aux_lock = 0;
    for (int w = 0; w < 2 && !busy; w++) tick;
    checks++;
    if ({busy, owner, ba_wr, ba_rd} !== 4'b1110 || ba_din !== 16'hC0DE ||
        ba_din_m !== 2'b01 || ba_addr !== 22'h000ABC) begin
      failures++; $display("FAIL lock_release got=%b/%h/%b/%h exp=1110/c0de/01/000abc",
                           {busy, owner, ba_wr, ba_rd}, ba_din, ba_din_m, ba_addr);
    end
    aux_lock = 1;
    tick;
    checks++;
    if ({busy, ba_wr} !== 2'b11) begin
      failures++; $display("FAIL lock_mid_grant got=%b exp=11", {busy, ba_wr});
    end
    ba_ack = 1; ba_rdy = 1; aux_wr = 0;
    tick;
    ba_ack = 0; ba_rdy = 0; aux_lock = 0;
    tick;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL lock_done got=%b exp=0", busy);
    end
  endtask

  task automatic test_timeout;
    aux_addr = 22'h000010; aux_rd = 1;
    tick;
    ba_ack = 1;
    tick;
    ba_ack = 0; aux_rd = 0;
    repeat (14) tick;
    checks++;
    if ({busy, tout} !== 2'b10) begin
      failures++; $display("FAIL tout_early got=%b exp=10", {busy, tout});
    end
    tick;
    checks++;
    if ({busy, tout} !== 2'b01) begin
      failures++; $display("FAIL tout_fire got=%b exp=01", {busy, tout});
    end
    game_rd = 1; game_addr = 22'h2222;
    tick;
    checks++;
    if ({busy, owner, ba_rd, tout} !== 4'b1011 || ba_addr !== 22'h2222) begin
      failures++; $display("FAIL tout_next_grant got=%b/%h exp=1011/002222", {busy, owner, ba_rd, tout}, ba_addr);
    end
    ba_ack = 1; ba_rdy = 1; game_rd = 0;
    tick;
    ba_ack = 0; ba_rdy = 0; #1;
    checks++;
    if ({busy, tout} !== 2'b01) begin
      failures++; $display("FAIL tout_sticky got=%b exp=01", {busy, tout});
    end
  endtask

  task automatic test_reset_mid_grant;
    game_rd = 1; game_addr = 22'h0777;
    tick;
    ba_ack = 1;
    tick;
    ba_ack = 0; #1;
    checks++;
    if ({busy, ba_rd} !== 2'b10) begin
      failures++; $display("FAIL mid_acked got=%b exp=10", {busy, ba_rd});
    end
    rst = 1; game_rd = 0;
    tick;
    rst = 0; #1;
    checks++;
    if ({ba_rd, busy, owner, tout} !== 4'b0000 || dut.starve_cnt !== 4'd0) begin
      failures++; $display("FAIL mid_reset got=%b/%0d exp=0000/0", {ba_rd, busy, owner, tout}, dut.starve_cnt);
    end
    ba_rdy = 1; #1;
    checks++;
    if ({game_rdy, aux_rdy} !== 2'b00) begin
      failures++; $display("FAIL idle_rdy_drop got=%b exp=00", {game_rdy, aux_rdy});
    end
    tick;
    ba_rdy = 0;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL idle_after_rdy got=%b exp=0", busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_game_read;
    test_aux_read;
    test_both_and_same_cycle;
    test_starvation;
    test_lock;
    test_timeout;
    test_reset_mid_grant;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/jtframe_ba_share.md
Name: jtframe_ba_share

Overview:
- Arbitrates one SDRAM bank port between the game (primary) and one auxiliary master (cheat/debug CPU, loader).
- Registered grant state machine that holds ownership from grant until the bank's rdy.
- Starvation guard so a busy game cannot lock out the aux master; lock input to fence the aux master off.
- Transaction timeout so a lost rdy cannot hang the bank.
- Sits between the game's bank-0 request bus and the SDRAM controller bank port.

Parameters:
- AW, 22, SDRAM word address width.
- STARVE, 8, consecutive game grants allowed while aux is pending (1..15).
- TOUTW, 8, timeout counter width; timeout after 2^TOUTW-1 cycles without rdy.

Ports:
- clk  in  1  SDRAM clock; only clock.
- rst  in  1  synchronous reset, active high.
- game_addr  in  AW  game word address.
- game_rd / game_wr  in  1  game request levels, held until game_ack.
- game_din  in  16  game write data.
- game_din_m  in  2  game byte mask.
- game_ack / game_dst / game_rdy  out  1  bank strobes routed to the game.
- aux_addr  in  AW  aux word address.
- aux_rd / aux_wr  in  1  aux request levels, held until aux_ack.
- aux_din  in  16  aux write data.
- aux_din_m  in  2  aux byte mask.
- aux_lock  in  1  1 = aux requests ignored (not granted).
- aux_ack / aux_dst / aux_rdy  out  1  bank strobes routed to aux.
- aux_dout  out  16  read data latched for aux.
- ba_addr  out  AW  bank address.
- ba_rd / ba_wr  out  1  bank request.
- ba_din  out  16  bank write data.
- ba_din_m  out  2  bank byte mask.
- ba_ack / ba_dst / ba_rdy  in  1  bank strobes.
- data_read  in  16  SDRAM read data.
- owner  out  1  0 = game, 1 = aux (valid while busy).
- busy  out  1  grant active.
- tout  out  1  sticky timeout flag.

Behaviour:
- Reset: state IDLE, owner=0, busy=0, acked=0, starve_cnt=0, tout=0, aux_dout=0, timer=0.
- Combinational ba_*/strobe outputs follow state, so all are 0 from the first cycle after the reset edge.

States: IDLE, GAME, AUX.
- IDLE:
  - game_req = game_rd|game_wr.
  - aux_req = (aux_rd|aux_wr) & ~aux_lock.
  - If aux_req and (starve_cnt>=STARVE or ~game_req): go to AUX, owner=1, starve_cnt=0.
  - Else if game_req: go to GAME, owner=0; starve_cnt += aux_req (saturating at 15).
  - No request: starve_cnt cleared when ~aux_req.
- GAME/AUX:
  - On ba_rdy: go to IDLE.
  - On timer == 2^TOUTW-1: go to IDLE and set tout.
  - Timer restarts at 0 on every grant.
- acked: set on ba_ack while GAME/AUX; cleared on entering IDLE.

Bank drive:
- IDLE: ba_rd = ba_wr = 0; ba_addr/din/din_m follow game.
- GAME: ba_* = game_* with rd/wr masked by ~acked.
- AUX: ba_* = aux_* with rd/wr masked by ~acked.

Strobe routing:
- game_ack = GAME & ba_ack; likewise game_dst and game_rdy.
- aux_ack = AUX & ba_ack; likewise aux_dst and aux_rdy.
- Strobes arriving in IDLE are dropped.

Data and status:
- aux_dout loads data_read on AUX & ba_dst; it holds otherwise.
- busy = state != IDLE.

Latency and edge cases:
- Grant latency: 1 cycle from request to ba_rd/ba_wr.
- Minimum one IDLE cycle between grants; back-to-back requests see 1 bubble.
- ack and rdy in the same cycle: both routed, return to IDLE.
- A requester dropping its request after grant does not abort; the grant ends only on rdy or timeout.
- aux_lock asserting during an AUX grant does not abort the grant.
- Reset mid-grant: immediate IDLE. The SDRAM controller is reset by the same rst.
- game_rd and game_wr both high: treated as a single request; ba mirrors both (controller's rule).

Decomposition:
- Shared package jtframe_sdram_pkg:
  - State encoding: IDLE=2'd0, GAME=2'd1, AUX=2'd2.
  - Strobe-bundle constants.
- No sub-module; the timeout counter stays inline.

Test Plan:
- Game-only read: game_rd=1 at addr 0x1234.
  - ba_rd=1 one cycle later with ba_addr=0x1234.
  - ba_ack → game_ack, ba_rd drops next cycle.
  - ba_rdy → game_rdy, busy=0.
- Aux read: aux_rd=1 at addr 0x3FFFFF, data_read=0xBEEF on ba_dst.
  - aux_dout=0xBEEF.
  - No game_* strobes asserted.
- Starvation: game requests continuously, aux_rd pending, STARVE=8.
  - Exactly 8 game grants, then an aux grant; starve_cnt returns to 0.
- Lock: aux_lock=1 with aux_wr pending, no game traffic.
  - No grant for 100 cycles.
  - After aux_lock=0, AUX grant within 2 cycles.
- Timeout: aux grant issued, ba_rdy withheld, TOUTW=4.
  - IDLE after 15 cycles, tout=1 sticky until rst.
  - Next game request is granted.
- Reset mid-grant: rst during GAME after ba_ack.
  - Next cycle ba_rd=0, busy=0, owner=0, starve_cnt=0.
  - A ba_rdy arriving in IDLE produces no game_rdy.
